// File: rtl/progmem_arbiter.sv
// ---------------------------------------------------------------------------
// progmem_arbiter
//
// Shares one read-only program-memory port between two bus masters using the
// PicoRV32 valid/ready/addr/rdata handshake: m0 (CPU fetch/load) and m1
// (debug/loader). Round-robin arbitration with one outstanding read at a time.
//
// The memory returns a registered, level-style ready (a registered copy of
// its valid && hit). This block turns that into a single-cycle ready pulse
// for the master that owns the transaction. Every output is registered.
//
// FSM: IDLE -> WAIT -> DONE -> IDLE
//   IDLE : grant a requester, launch s_valid/s_addr
//   WAIT : wait for s_ready (and, in the timeout build, abort after TIMEOUT)
//   DONE : ready pulse visible to the owner; stale s_ready is ignored here
//
// Build option:
//   PROGMEM_ARB_TIMEOUT_EN  - when defined, a WAIT-cycle counter aborts a read
//                             that has not completed after TIMEOUT cycles and
//                             returns ERR_WORD with m_err. When undefined there
//                             is no counter, m_err stays 0 and WAIT can hang.
//
// Parameters:
//   ADDR_W    address width
//   DATA_W    data width
//   TIMEOUT   WAIT cycles before abort (timeout build only), must be >= 2
//   ERR_WORD  rdata returned on abort (EBREAK)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_valid/m0_addr          m0 request (held until m0_ready)
//   m0_ready/m0_rdata         m0 one-cycle completion pulse and read data
//   m1_*                      same as m0, for m1
//   s_valid/s_addr            registered request towards progmem
//   s_ready/s_rdata           progmem completion and data
//   m_err                     pulses together with mN_ready on an aborted read
//   busy                      1 in any state except IDLE
// ---------------------------------------------------------------------------
module progmem_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_WORD = 32'h0010_0073
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              m_err,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Elaboration-time sanity check on the abort threshold.
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("progmem_arbiter: TIMEOUT must be >= 2");
  end

  // Registered state.
  logic [1:0]        state_q,    state_d;
  logic              s_valid_q,  s_valid_d;
  logic [ADDR_W-1:0] s_addr_q,   s_addr_d;
  logic              owner_q,    owner_d;   // 0 = m0, 1 = m1
  logic              last_q,     last_d;    // last granted master
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m_err_q,    m_err_d;
  logic              busy_q,     busy_d;

  // Combinational helpers.
  logic              timeout_hit_s;
  logic              winner_s;
  logic              finish_s;
  logic              fin_err_s;
  logic [DATA_W-1:0] fin_data_s;

`ifdef PROGMEM_ARB_TIMEOUT_EN
  localparam int CTR_W = $clog2(TIMEOUT + 1);

  logic [CTR_W-1:0] ctr_q, ctr_d;

  // The counter is zero outside WAIT, so it is already clear on entry and
  // counts the WAIT cycles elapsed since s_valid went out.
  always_comb begin
    if (state_q == ST_WAIT) begin
      ctr_d = ctr_q + CTR_W'(1);
    end else begin
      ctr_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign timeout_hit_s = (state_q == ST_WAIT) && (ctr_q == CTR_W'(TIMEOUT));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and output logic of the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    s_valid_d  = s_valid_q;
    s_addr_d   = s_addr_q;
    owner_d    = owner_q;
    last_d     = last_q;
    m0_ready_d = m0_ready_q;
    m1_ready_d = m1_ready_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m_err_d    = m_err_q;
    winner_s   = 1'b0;
    finish_s   = 1'b0;
    fin_err_s  = 1'b0;
    fin_data_s = '0;

    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          // A tie goes to the master that was not granted last time.
          if (m0_valid && m1_valid) begin
            winner_s = ~last_q;
          end else begin
            winner_s = m1_valid;
          end
          s_valid_d = 1'b1;
          s_addr_d  = winner_s ? m1_addr : m0_addr;
          owner_d   = winner_s;
          last_d    = winner_s;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // A real completion beats an abort that lands in the same cycle.
        if (s_ready) begin
          finish_s   = 1'b1;
          fin_data_s = s_rdata;
          fin_err_s  = 1'b0;
        end else if (timeout_hit_s) begin
          finish_s   = 1'b1;
          fin_data_s = ERR_WORD;
          fin_err_s  = 1'b1;
        end else begin
          finish_s   = 1'b0;
        end

        if (finish_s) begin
          if (owner_q) begin
            m1_rdata_d = fin_data_s;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = fin_data_s;
            m0_ready_d = 1'b1;
          end
          m_err_d   = fin_err_s;
          s_valid_d = 1'b0;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        // s_ready may still be high for one cycle here; it is not looked at.
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        m_err_d    = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        s_valid_d  = 1'b0;
        m0_ready_d = 1'b0;
        m1_ready_d = 1'b0;
        m_err_d    = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s_valid_q  <= 1'b0;
      s_addr_q   <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m_err_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_valid_q  <= s_valid_d;
      s_addr_q   <= s_addr_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m_err_q    <= m_err_d;
      busy_q     <= busy_d;
    end
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m_err    = m_err_q;
  assign busy     = busy_q;

endmodule
